// File: rtl/puzzle_move_replay.sv
// Replays a packed 8-puzzle move list against a start board, streaming each board over valid/ready.
// One board per cycle under full out_ready; a done pulse with err/solved follows the last accepted board.
module puzzle_move_replay (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [39:0] start_board,
    input  logic [29:0] start_moves,
    input  logic [3:0]  start_len,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [39:0] out_board,
    output logic [3:0]  out_step,
    output logic        out_last,
    output logic        done,
    output logic        err,
    output logic        solved
);

    localparam logic [39:0] GOAL = 40'h8123456780;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [39:0] board_q, board_d;
    logic [29:0] moves_q, moves_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  step_q, step_d;
    logic        err_q, err_d;
    logic        solved_q, solved_d;

    logic [3:0]  blank;
    logic [3:0]  nb;
    logic [1:0]  mv;
    logic        legal;
    logic [3:0]  tile_b;
    logic [3:0]  tile_nb;
    logic [39:0] next_board;

    assign blank = board_q[39:36];

    // Move selection, destination of the blank, and legality of the current step.
    always_comb begin
        mv = 2'b00;
        for (int k = 0; k < 15; k++) begin
            if (step_q == 4'(k)) mv = moves_q[2*k +: 2];
        end
        legal = 1'b0;
        nb    = blank;
        case (mv)
            2'b00: begin
                legal = (blank >= 4'd3);
                nb    = blank - 4'd3;
            end
            2'b01: begin
                legal = (blank <= 4'd5);
                nb    = blank + 4'd3;
            end
            2'b10: begin
                legal = (blank != 4'd0) && (blank != 4'd3) && (blank != 4'd6);
                nb    = blank - 4'd1;
            end
            default: begin
                legal = (blank != 4'd2) && (blank != 4'd5) && (blank != 4'd8);
                nb    = blank + 4'd1;
            end
        endcase
    end

    // Swap the blank cell with its destination; tile contents are carried as-is.
    always_comb begin
        tile_b     = 4'h0;
        tile_nb    = 4'h0;
        next_board = board_q;
        for (int i = 0; i < 9; i++) begin
            if (blank == 4'(i)) tile_b  = board_q[35-4*i -: 4];
            if (nb == 4'(i))    tile_nb = board_q[35-4*i -: 4];
        end
        for (int i = 0; i < 9; i++) begin
            if (blank == 4'(i)) next_board[35-4*i -: 4] = tile_nb;
            if (nb == 4'(i))    next_board[35-4*i -: 4] = tile_b;
        end
        next_board[39:36] = nb;
    end

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        moves_d  = moves_q;
        len_d    = len_q;
        step_d   = step_q;
        err_d    = err_q;
        solved_d = solved_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    board_d  = start_board;
                    moves_d  = start_moves;
                    len_d    = start_len;
                    step_d   = 4'd0;
                    err_d    = 1'b0;
                    solved_d = 1'b0;
                    if (start_board[39:36] > 4'd8) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (step_q == len_q) begin
                        solved_d = (board_q == GOAL) && !err_q;
                        state_d  = S_DONE;
                    end else if (legal) begin
                        board_d = next_board;
                        step_d  = step_q + 4'd1;
                    end else begin
                        err_d    = 1'b1;
                        solved_d = 1'b0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            board_q  <= 40'h0;
            moves_q  <= 30'h0;
            len_q    <= 4'd0;
            step_q   <= 4'd0;
            err_q    <= 1'b0;
            solved_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            moves_q  <= moves_d;
            len_q    <= len_d;
            step_q   <= step_d;
            err_q    <= err_d;
            solved_q <= solved_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_EMIT);
    assign out_board   = board_q;
    assign out_step    = step_q;
    assign out_last    = (state_q == S_EMIT) && (step_q == len_q);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign solved      = solved_q;

endmodule

// File: tb/tb_puzzle_move_replay.sv
// Directed bench for puzzle_move_replay: vector table of whole runs plus hand-written multi-cycle sequences.
module tb_puzzle_move_replay;

    localparam logic [39:0] GOAL = 40'h8123456780;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [39:0] start_board = 40'h0;
    logic [29:0] start_moves = 30'h0;
    logic [3:0]  start_len = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [39:0] out_board;
    logic [3:0]  out_step;
    logic        out_last;
    logic        done;
    logic        err;
    logic        solved;

    puzzle_move_replay dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_board (start_board),
        .start_moves (start_moves),
        .start_len   (start_len),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_board   (out_board),
        .out_step    (out_step),
        .out_last    (out_last),
        .done        (done),
        .err         (err),
        .solved      (solved)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0]       board;
        logic [29:0]       moves;
        logic [3:0]        len;
        int                n_out;
        logic [3:0][39:0]  exp_b;
        logic              exp_err;
        logic              exp_solved;
    } vec_t;

    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_run(input logic [39:0] b, input logic [29:0] m, input logic [3:0] l);
        @(negedge clk);
        chk("start_ready_idle", start_ready, 1);
        start_valid = 1'b1;
        start_board = b;
        start_moves = m;
        start_len   = l;
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    task automatic run_vec(input int v);
        int  idx;
        bit  seen;
        idx  = 0;
        seen = 0;
        out_ready = 1'b1;
        start_run(vecs[v].board, vecs[v].moves, vecs[v].len);
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == 0) chk("first_valid", out_valid, 1);
            if (out_valid) begin
                if (idx < vecs[v].n_out) begin
                    chk($sformatf("v%0d_board%0d", v, idx), out_board, vecs[v].exp_b[idx]);
                    chk($sformatf("v%0d_step%0d", v, idx), out_step, idx);
                    chk($sformatf("v%0d_last%0d", v, idx), out_last, (idx == int'(vecs[v].len)));
                end else begin
                    chk($sformatf("v%0d_n_boards", v), idx + 1, vecs[v].n_out);
                end
                idx++;
            end else if (done) begin
                seen = 1;
                chk($sformatf("v%0d_done_cycle", v), cyc, vecs[v].n_out);
                chk($sformatf("v%0d_count", v), idx, vecs[v].n_out);
                chk($sformatf("v%0d_err", v), err, vecs[v].exp_err);
                chk($sformatf("v%0d_solved", v), solved, vecs[v].exp_solved);
                chk($sformatf("v%0d_ready_in_done", v), start_ready, 0);
            end
        end
        chk($sformatf("v%0d_done_seen", v), seen, 1);
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse", v), done, 0);
        chk($sformatf("v%0d_ready_after", v), start_ready, 1);
        chk($sformatf("v%0d_err_held", v), err, vecs[v].exp_err);
        chk($sformatf("v%0d_solved_held", v), solved, vecs[v].exp_solved);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 5; i++) begin
            vecs[i].exp_b      = '0;
            vecs[i].moves      = 30'h0;
            vecs[i].exp_err    = 1'b0;
            vecs[i].exp_solved = 1'b0;
        end
        // Goal board, no moves
        vecs[0].board = GOAL; vecs[0].len = 4'd0; vecs[0].n_out = 1;
        vecs[0].exp_b[0] = GOAL; vecs[0].exp_solved = 1'b1;
        // RIGHT then DOWN solves it
        vecs[1].board = 40'h4123405786; vecs[1].moves = 30'h7; vecs[1].len = 4'd2; vecs[1].n_out = 3;
        vecs[1].exp_b[0] = 40'h4123405786; vecs[1].exp_b[1] = 40'h5123450786;
        vecs[1].exp_b[2] = GOAL; vecs[1].exp_solved = 1'b1;
        // UP with the blank in the top row is illegal
        vecs[2].board = 40'h0012345678; vecs[2].moves = 30'h0; vecs[2].len = 4'd1; vecs[2].n_out = 1;
        vecs[2].exp_b[0] = 40'h0012345678; vecs[2].exp_err = 1'b1;
        // LEFT, LEFT, UP from goal: legal but unsolved
        vecs[3].board = GOAL; vecs[3].moves = 30'h0A; vecs[3].len = 4'd3; vecs[3].n_out = 4;
        vecs[3].exp_b[0] = GOAL; vecs[3].exp_b[1] = 40'h7123456708;
        vecs[3].exp_b[2] = 40'h6123456078; vecs[3].exp_b[3] = 40'h3123056478;
        // UP then RIGHT from the right column: fails at step 1
        vecs[4].board = GOAL; vecs[4].moves = 30'hC; vecs[4].len = 4'd2; vecs[4].n_out = 2;
        vecs[4].exp_b[0] = GOAL; vecs[4].exp_b[1] = 40'h5123450786; vecs[4].exp_err = 1'b1;

        // Reset state
        #2;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_board", out_board, 0);
        chk("rst_out_step", out_step, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_solved", solved, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) run_vec(v);

        // Backpressure: hold out_ready low for 5 cycles at step 1
        out_ready = 1'b1;
        start_run(40'h4123405786, 30'h7, 4'd2);
        @(negedge clk);
        chk("bp_step0", out_step, 0);
        @(negedge clk);
        chk("bp_step1", out_step, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_board%0d", i), out_board, 40'h5123450786);
            chk($sformatf("bp_hold_step%0d", i), out_step, 1);
            chk($sformatf("bp_hold_valid%0d", i), out_valid, 1);
            chk($sformatf("bp_hold_last%0d", i), out_last, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_board", out_board, GOAL);
        chk("bp_resume_step", out_step, 2);
        chk("bp_resume_last", out_last, 1);
        @(negedge clk);
        chk("bp_done", done, 1);
        chk("bp_solved", solved, 1);
        chk("bp_err", err, 0);

        // Bad blank index
        start_run(40'h9123456780, 30'h0, 4'd0);
        @(negedge clk);
        chk("bad_valid", out_valid, 0);
        chk("bad_done", done, 1);
        chk("bad_err", err, 1);
        chk("bad_solved", solved, 0);
        @(negedge clk);
        chk("bad_valid2", out_valid, 0);
        chk("bad_done2", done, 0);
        chk("bad_ready2", start_ready, 1);

        // Reset in the middle of a run, then restart immediately
        start_run(40'h4123405786, 30'h7, 4'd2);
        @(negedge clk);
        @(negedge clk);
        chk("mr_step1", out_step, 1);
        rst = 1'b1;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_board", out_board, 0);
        chk("mr_step", out_step, 0);
        chk("mr_last", out_last, 0);
        chk("mr_done", done, 0);
        chk("mr_ready", start_ready, 1);
        @(negedge clk);
        chk("mr_done_held", done, 0);
        rst = 1'b0;
        start_valid = 1'b1;
        start_board = GOAL;
        start_moves = 30'h0;
        start_len   = 4'd0;
        @(posedge clk);
        #1 start_valid = 1'b0;
        @(negedge clk);
        chk("mr_new_valid", out_valid, 1);
        chk("mr_new_board", out_board, GOAL);
        chk("mr_new_last", out_last, 1);
        @(negedge clk);
        chk("mr_new_done", done, 1);
        chk("mr_new_solved", solved, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/puzzle_move_replay.md
# puzzle_move_replay

Sequential replay engine for the 8-puzzle datapath. It accepts a start board plus a packed list of up to 15 moves. It applies the moves one per step, in order, and streams every intermediate board out over a valid/ready interface. At the end it reports whether the final board equals the goal. This block is the consumer of the move history that the board-transform ALU produces, and it turns that history back into a board sequence for display or checking.

## Interface
- GOAL, 40'h8123456780, goal board (blank at index 8; tiles 1..8 then 0)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_valid  in  1  start request
- start_ready  out  1  high only in IDLE
- start_board  in  40  initial board
- start_moves  in  30  packed move list; move k at [2k+1:2k], k=0 first
- start_len  in  4  number of moves, 0..15
- out_valid  out  1  out_board valid
- out_ready  in  1  downstream accepts
- out_board  out  40  current board
- out_step  out  4  moves applied so far
- out_last  out  1  out_step == len
- done  out  1  one-cycle completion pulse
- err  out  1  run aborted; held until next start accept
- solved  out  1  final board == GOAL; held until next start accept

## Operation
- Board format: [39:36] blank index b (0..8, row-major, b = 3*row+col). Cell i occupies [35-4i:32-4i]. The blank cell holds 0.
- Move codes and their effect on the blank:
  - 00 UP: b-3, legal if b>=3
  - 01 DOWN: b+3, legal if b<=5
  - 10 LEFT: b-1, legal if b%3!=0
  - 11 RIGHT: b+1, legal if b%3!=2
- Applying a move swaps cell b with cell b' and sets [39:36]=b'. All other cells are unchanged.
- FSM states: IDLE, EMIT, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready, latch board, moves, len; clear step, err, solved.
  - If start_board[39:36]>8, go to DONE with err=1.
  - Otherwise go to EMIT.
- EMIT:
  - out_valid=1; out_board, out_step, out_last come from registers.
  - On a handshake with step==len, go to DONE.
  - On a handshake with step<len, evaluate move[step]:
    - Legal: register the new board, step+1, stay in EMIT.
    - Illegal: err=1, board unchanged, go to DONE.
  - No handshake: hold every output.
- DONE:
  - done=1 for exactly one cycle.
  - solved=(board==GOAL)&!err, registered on entry.
  - Go to IDLE.
- The number of boards emitted is len+1 on success (step 0 is the start board). On an illegal move, boards are emitted only up to the failing step.
- Tile contents are not validated; only the blank index is checked.

## Timing
- Reset values: state=IDLE, start_ready=1, out_valid=0, out_board=0, out_step=0, out_last=0, done=0, err=0, solved=0.
- Reset mid-run abandons the run with no done pulse. The first cycle after reset release is IDLE.
- Start accept at edge N: out_valid=1 with step 0 from cycle N+1.
- Throughput is one board per cycle when out_ready is held high; there are no bubbles between steps.
- Backpressure: while out_valid&!out_ready, out_board, out_step and out_last stay stable.
- Last handshake at edge M: cycle M+1 has done=1, out_valid=0, start_ready=0, and err/solved valid. Cycle M+2 is IDLE with start_ready=1.
- Bad start index at edge N: done=1 in cycle N+1, and out_valid never rises.
- The next-board swap logic is combinational on the registered board and move[step]. Only registers drive outputs; start_ready, out_valid and out_last decode from registered state.
- start_* inputs are ignored outside IDLE.

## Test plan
- Goal start, no moves: start_board=40'h8123456780, len=0.
  - Expect one board, step 0, out_last=1.
  - Then done with solved=1, err=0.
- Two-move solve: start_board=40'h4123405786, moves=30'h7 (RIGHT, then DOWN), len=2.
  - Expect boards 40'h4123405786, 40'h5123450786, 40'h8123456780 at steps 0/1/2, back-to-back.
  - Then solved=1.
- Illegal move: start_board=40'h0012345678, moves=0 (UP), len=1.
  - Expect only step 0 emitted.
  - Then done with err=1, solved=0.
- Backpressure: the two-move solve run with out_ready low for 5 cycles at step 1.
  - out_board must hold 40'h5123450786 and out_step must hold 1.
  - The sequence must then resume unchanged.
- Bad blank index: start_board=40'h9123456780.
  - out_valid never rises.
  - done pulses next cycle with err=1.
- Reset mid-run: assert rst during step 1 of the two-move solve.
  - All outputs return to reset values, with no done pulse.
  - A new start is accepted right after reset release.
